// File: rtl/tero_response_collector.sv
// tero_response_collector: counts edges of the selected TERO loop, averages them on each store pulse, and drains the per-loop buffer over valid/ready.
// Optional `TERO_OSC_SYNC_EN`: 2-flop synchronizer + edge detect on osc_in; undefined treats osc_in as clk-synchronous pulses.

module tero_osc_lane (
  input  logic clk,
  input  logic reset,
  input  logic osc,
  output logic edge_evt
);
`ifdef TERO_OSC_SYNC_EN
  // sh[0]/sh[1] synchronize, sh[2] holds the previous synchronized value
  logic [2:0] sh;
  always_ff @(posedge clk or posedge reset)
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], osc};
  assign edge_evt = sh[1] & ~sh[2];
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ reset;
  assign edge_evt       = osc;
`endif
endmodule

module tero_response_collector #(
  parameter  int NUM_LOOPS        = 4,
  parameter  int REPETITIONS_LOG2 = 12,
  parameter  int ACC_BITS         = 32,
  parameter  int RESP_BITS        = 16,
  localparam int SEL_W            = $clog2(NUM_LOOPS-1)+1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reset_puf,
  input  logic [SEL_W-1:0]     select_puf,
  input  logic                 enable_puf,
  input  logic                 store_response_puf,
  input  logic                 done,
  input  logic [NUM_LOOPS-1:0] osc_in,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [SEL_W-1:0]     resp_index,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_written,
  output logic                 resp_saturated,
  output logic                 busy
);
  localparam int IDX_W = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
  localparam int W     = (ACC_BITS > RESP_BITS) ? ACC_BITS : RESP_BITS;
  localparam logic [SEL_W-1:0]    SEL_END    = SEL_W'(NUM_LOOPS);
  localparam logic [SEL_W-1:0]    SEL_LAST   = SEL_W'(NUM_LOOPS-1);
  localparam logic [ACC_BITS-1:0] ACC_MAX    = '1;
  localparam logic [W-1:0]        RESP_MAX_W = W'({RESP_BITS{1'b1}});

  typedef enum logic [1:0] {COLLECT, DRAIN, WAIT_LOW} state_t;

  state_t                             state, state_nx;
  logic [SEL_W-1:0]                   ptr;
  logic [ACC_BITS-1:0]                acc;
  logic                               sat;
  logic [NUM_LOOPS-1:0][RESP_BITS-1:0] mem;
  logic [NUM_LOOPS-1:0]               written, satflag;
  logic [NUM_LOOPS-1:0]               osc_edge;

  logic                 sel_ok, count_en, store_en, accept, last_accept;
  logic [IDX_W-1:0]     sel_idx, ptr_idx;
  logic [W-1:0]         acc_shr;
  logic [RESP_BITS-1:0] avg;

  for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_lane
    tero_osc_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .osc      (osc_in[g]),
      .edge_evt (osc_edge[g])
    );
  end

  assign sel_ok      = select_puf < SEL_END;
  assign sel_idx     = select_puf[IDX_W-1:0];
  assign ptr_idx     = ptr[IDX_W-1:0];
  assign count_en    = enable_puf & sel_ok & osc_edge[sel_idx];
  assign store_en    = (state == COLLECT) & store_response_puf & sel_ok;
  assign accept      = (state == DRAIN) & resp_ready;
  assign last_accept = accept & (ptr == SEL_LAST);

  // average by shift, clamped to the response width
  assign acc_shr = W'(acc >> REPETITIONS_LOG2);
  assign avg     = (acc_shr > RESP_MAX_W) ? '1 : acc_shr[RESP_BITS-1:0];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (reset_puf) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (count_en && acc != ACC_MAX) begin
      acc <= acc + ACC_BITS'(1);
      if (acc == ACC_MAX - ACC_BITS'(1)) sat <= 1'b1;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ptr     <= '0;
      mem     <= '0;
      written <= '0;
      satflag <= '0;
    end else begin
      if (store_en) begin
        mem[sel_idx]     <= avg;
        written[sel_idx] <= 1'b1;
        satflag[sel_idx] <= sat;
      end
      if (state == COLLECT && done)  ptr <= '0;
      else if (accept && !last_accept) ptr <= ptr + SEL_W'(1);
      if (last_accept) written <= '0;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= COLLECT;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      COLLECT:  if (done)        state_nx = DRAIN;
      DRAIN:    if (last_accept) state_nx = WAIT_LOW;
      WAIT_LOW: if (!done)       state_nx = COLLECT;
      default:                   state_nx = COLLECT;
    endcase
  end

  always_comb begin
    resp_valid     = 1'b0;
    resp_index     = '0;
    resp_data      = '0;
    resp_written   = 1'b0;
    resp_saturated = 1'b0;
    busy           = 1'b0;
    case (state)
      DRAIN: begin
        resp_valid     = 1'b1;
        resp_index     = ptr;
        resp_data      = mem[ptr_idx];
        resp_written   = written[ptr_idx];
        resp_saturated = satflag[ptr_idx];
        busy           = 1'b1;
      end
      WAIT_LOW: busy = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tero_response_collector.sv
// Scoreboard bench for tero_response_collector (osc_in as pulses): a behavioural model predicts each drained entry.
module tb_tero_response_collector;
  localparam int NL = 4, RL = 2, AB = 12, RB = 9, SW = 3;
  localparam int ACC_MAX = (1 << AB) - 1;
  localparam int RESP_MAX = (1 << RB) - 1;

  logic clk = 1'b0;
  logic reset, reset_puf, enable_puf, store_response_puf, done, resp_ready;
  logic [SW-1:0] select_puf;
  logic [NL-1:0] osc_in;
  logic resp_valid, resp_written, resp_saturated, busy;
  logic [SW-1:0] resp_index;
  logic [RB-1:0] resp_data;

  always #5 clk = ~clk;

  tero_response_collector #(
    .NUM_LOOPS(NL), .REPETITIONS_LOG2(RL), .ACC_BITS(AB), .RESP_BITS(RB)
  ) dut (
    .clk(clk), .reset(reset), .reset_puf(reset_puf), .select_puf(select_puf),
    .enable_puf(enable_puf), .store_response_puf(store_response_puf), .done(done),
    .osc_in(osc_in), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_index(resp_index), .resp_data(resp_data), .resp_written(resp_written),
    .resp_saturated(resp_saturated), .busy(busy)
  );

  typedef struct {int idx; int data; int wr; int sat;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0, n_fail = 0;
  int m_mem[NL], m_wr[NL], m_sat[NL];
  int m_acc, m_satf;
  int held_v = 0, held_idx, held_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clampv(input int v);
    return (v > RESP_MAX) ? RESP_MAX : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin m_mem[i] = 0; m_wr[i] = 0; m_sat[i] = 0; end
    m_acc = 0; m_satf = 0;
  endtask

  // drive one cycle of inputs and advance the model to the edge that samples them
  task automatic cyc(input bit rp, input bit en, input bit st, input int sel,
                     input logic [NL-1:0] osc, input bit dn);
    reset_puf = rp; enable_puf = en; store_response_puf = st;
    select_puf = SW'(sel); osc_in = osc; done = dn;
    if (st && sel < NL) begin
      m_mem[sel] = clampv(m_acc >> RL); m_wr[sel] = 1; m_sat[sel] = m_satf;
    end
    if (rp) begin
      m_acc = 0; m_satf = 0;
    end else if (en && sel < NL && osc[sel] === 1'b1 && m_acc < ACC_MAX) begin
      m_acc++;
      if (m_acc == ACC_MAX) m_satf = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_loop(input int sel, input int n);
    logic [NL-1:0] oh;
    oh = NL'(1 << sel);
    cyc(1, 0, 0, sel, '0, 0);
    repeat (n) cyc(0, 1, 0, sel, oh, 0);
    cyc(0, 0, 1, sel, '0, 0);
  endtask

  task automatic drain(input int stall);
    int n_valid, held, guard;
    n_valid = 0; held = 0; guard = 0;
    for (int i = 0; i < NL; i++) exp_q.push_back('{i, m_mem[i], m_wr[i], m_sat[i]});
    cyc(0, 0, 0, 0, '0, 1);
    done = 1'b0;
    do begin
      if (resp_valid) n_valid++;
      if (stall > 0 && resp_valid && resp_index == 3'd2 && held < stall) begin
        resp_ready = 1'b0; held++;
      end else resp_ready = 1'b1;
      @(posedge clk); #1;
      guard++;
    end while (busy && guard < 64);
    resp_ready = 1'b1;
    chk("drain_in_time", guard < 64, 1);
    chk("drain_cycles", n_valid, NL + stall);
    chk("busy_after", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < NL; i++) m_wr[i] = 0;
  endtask

  always @(negedge clk) if (reset === 1'b0) begin
    if (resp_valid) begin
      if (held_v != 0) begin
        chk("hold_index", resp_index, held_idx);
        chk("hold_data", resp_data, held_data);
      end
      if (resp_ready) begin
        held_v = 0;
        if (exp_q.size() == 0) chk("extra_entry", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("index", resp_index, mon_e.idx);
          chk("data", resp_data, mon_e.data);
          chk("written", resp_written, mon_e.wr);
          chk("saturated", resp_saturated, mon_e.sat);
        end
      end else begin
        held_v = 1; held_idx = resp_index; held_data = resp_data;
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1; reset_puf = 0; enable_puf = 0; store_response_puf = 0;
    done = 0; select_puf = '0; osc_in = '0; resp_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_index", resp_index, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_written", resp_written, 0);
    chk("rst_saturated", resp_saturated, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // basic capture: 10 edges on loop 1 -> 2
    run_loop(1, 10);
    drain(0);

    // full run then the same run with backpressure on entry 2
    for (int l = 0; l < NL; l++) run_loop(l, (l + 1) * 400);
    drain(0);
    for (int l = 0; l < NL; l++) run_loop(l, (l + 1) * 400);
    drain(5);

    // saturation on loop 3, then reset_puf clears sat for loop 2
    run_loop(3, ACC_MAX + 100);
    run_loop(2, 8);
    drain(0);

    // boundary events
    cyc(1, 0, 0, 0, '0, 0);
    repeat (7) cyc(0, 1, 0, 0, 4'b0001, 0);
    cyc(0, 1, 1, 0, 4'b0001, 0);
    cyc(0, 0, 1, 1, '0, 0);
    cyc(1, 1, 0, 2, 4'b0100, 0);
    cyc(0, 0, 1, 2, '0, 0);
    repeat (4) cyc(0, 1, 0, 5, 4'b1111, 0);
    cyc(0, 0, 1, 4, '0, 0);
    cyc(0, 0, 1, 3, '0, 0);
    drain(0);

    // reset while entry 1 is presented
    run_loop(0, 40);
    run_loop(1, 80);
    for (int i = 0; i < NL; i++) exp_q.push_back('{i, m_mem[i], m_wr[i], m_sat[i]});
    cyc(0, 0, 0, 0, '0, 1);
    done = 1'b0;
    guard = 0;
    while (!(resp_valid && resp_index == 3'd1) && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk("reach_entry1", guard < 20, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_index", resp_index, 0);
    chk("mid_rst_data", resp_data, 0);
    chk("mid_rst_written", resp_written, 0);
    chk("mid_rst_saturated", resp_saturated, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_popped", exp_q.size(), NL - 1);
    exp_q.delete();
    held_v = 0;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tero_response_collector.md
# tero_response_collector

Consumer end of the TERO evaluation handshake. It takes the sequencer's `reset_puf`, `select_puf`, `enable_puf`, `store_response_puf` and `done` outputs, and counts oscillation edges of the selected TERO loop into a shared accumulator. On each store pulse it averages the accumulated count over the repetitions and writes the result into a per-loop response buffer. When `done` is seen, it streams the buffer out over a valid/ready port.

## Interface
- `NUM_LOOPS`, 4: number of TERO loops, and the number of buffer entries.
- `REPETITIONS_LOG2`, 12: log2 of the sequencer's repetition count; this is the average shift amount.
- `ACC_BITS`, 32: width of the shared oscillation accumulator.
- `RESP_BITS`, 16: width of a stored response.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `reset_puf` in 1: clears the accumulator.
- `select_puf` in `$clog2(NUM_LOOPS-1)+1`: index of the loop being evaluated.
- `enable_puf` in 1: counting window.
- `store_response_puf` in 1: one-cycle capture pulse.
- `done` in 1: the sequencer has finished a run.
- `osc_in` in NUM_LOOPS: raw TERO loop outputs, one bit per loop.
- `resp_valid` out 1: an output entry is presented.
- `resp_ready` in 1: the downstream side accepts the entry.
- `resp_index` out `$clog2(NUM_LOOPS-1)+1`: index of the entry.
- `resp_data` out RESP_BITS: averaged oscillation count.
- `resp_written` out 1: the entry was stored during this run.
- `resp_saturated` out 1: the accumulator saturated before this entry was stored.
- `busy` out 1: high in DRAIN and WAIT_LOW.

## Operation
- FSM states are COLLECT, DRAIN and WAIT_LOW. Reset enters COLLECT.
- **Counting, all states:**
  - Edge event = rising edge of `osc_in[select_puf]`.
  - The edge is taken after the input stage defined under Configuration.
  - The accumulator increments by 1 when `enable_puf` is high and an edge event occurs in the same cycle.
  - When `select_puf >= NUM_LOOPS`, no edge event is taken.
- **Saturation:**
  - The accumulator holds at `2^ACC_BITS-1`; it never wraps.
  - A sticky `sat` flag sets when the accumulator saturates.
  - `reset_puf` clears both the accumulator and `sat`.
  - `reset_puf` has priority over an increment in the same cycle.
- **Store, COLLECT only:**
  - Triggered when `store_response_puf` is high and `select_puf < NUM_LOOPS`.
  - `mem[select_puf] <= min((acc >> REPETITIONS_LOG2), 2^RESP_BITS-1)`.
  - `written[select_puf] <= 1`; `satflag[select_puf] <= sat`.
  - The stored value is the accumulator's registered value. An edge counted in the same cycle as the store is not included.
- **Ignored stores:** a store pulse in DRAIN or WAIT_LOW, or with an out-of-range index, is ignored.
- **COLLECT → DRAIN:** taken when `done` is high. The read pointer is set to 0.
- **DRAIN:**
  - Entry `ptr` is presented: `resp_valid=1`, `resp_index=ptr`, `resp_data=mem[ptr]`, `resp_written=written[ptr]`, `resp_saturated=satflag[ptr]`.
  - All NUM_LOOPS entries are emitted in order 0..NUM_LOOPS-1, including entries that were never written (those have `resp_written=0`).
  - When `resp_valid & resp_ready`, `ptr` increments.
  - After entry NUM_LOOPS-1 is accepted, the FSM moves to WAIT_LOW and clears all `written` bits.
- **WAIT_LOW:** stays until `done` is low, then returns to COLLECT. `mem` contents are retained but are marked unwritten.
- **`reset_puf` in DRAIN:** clears only the accumulator; the drain continues.
- **`reset` at any point:** returns to COLLECT with the pointer, accumulator, `written`, `satflag` and `mem` all cleared.

## Timing
- Reset values of outputs: `resp_valid=0`, `resp_index=0`, `resp_data=0`, `resp_written=0`, `resp_saturated=0`, `busy=0`.
- The accumulator updates on the clk edge after a qualified edge event.
- A store is written on the clk edge at which `store_response_puf` is sampled high. The sequencer holds the pulse for exactly one cycle, and the store uses `select_puf` from that same cycle.
- `resp_valid` rises on the first cycle after `done` is sampled high in COLLECT.
- The presented entry changes only on the edge that follows a handshake.
- `resp_valid`, `resp_index` and `resp_data` are registered or decoded from registered state only; they never depend combinationally on `resp_ready`.
- With `resp_ready` tied high, the drain takes NUM_LOOPS cycles, one entry per cycle.
- `done` must be high for one sampled edge to trigger the drain. `done` dropping during DRAIN does not abort the drain.

## Configuration
- `TERO_OSC_SYNC_EN` defined:
  - Each `osc_in` bit passes through a 2-flop synchronizer plus a previous-value flop.
  - Edge event = `sync & ~prev`, so edge-to-count latency is 3 cycles.
  - Edges still in the pipeline when `enable_puf` falls are dropped.
  - Loops must toggle no faster than clk/2.
- `TERO_OSC_SYNC_EN` undefined:
  - `osc_in` is treated as clk-synchronous single-cycle event pulses.
  - Edge event = `osc_in[select_puf]` high in that cycle, with zero added latency.

## Test plan
- **Basic capture:** run with macro undefined, REPETITIONS_LOG2=2, `reset_puf` pulse, `enable_puf` held 10 cycles with `osc_in[1]` high throughout, store with `select_puf=1`. Required: `mem[1]=2` (10>>2), `written[1]=1`.
- **Full run and drain:** capture loops 0..3 with accumulators 400/800/1200/1600 (REPETITIONS_LOG2=2), pulse `done`, `resp_ready=1`. Required: entries 0..3 over 4 consecutive cycles with data 100/200/300/400, all with `resp_written=1`; `busy` falls after `done` is low.
- **Backpressure:** same as the full run, but `resp_ready` low for 5 cycles on entry 2. Required: `resp_index=2` with `resp_data=300` held stable; no entry skipped or repeated.
- **Saturation:** ACC_BITS=8, 300 edge events, then store. Required: accumulator=255, `resp_saturated=1` on that entry; the next `reset_puf` clears `sat`.
- **Boundary events:** store and edge in the same cycle; `reset_puf` and edge in the same cycle; `select_puf=NUM_LOOPS` with a store. Required: the store excludes the same-cycle edge; the accumulator is 0 after the `reset_puf` cycle; the out-of-range store is ignored.
- **Reset mid-drain:** assert `reset` during entry 1. Required: all outputs immediately at their reset values; the next drain shows every entry with `resp_written=0` and `resp_data=0`.
